// File: rtl/vga_rect_writer.sv
`default_nettype none
// ============================================================================
// Module   : vga_rect_writer
// Brief    : Rectangle-fill write engine for the 640x480 8-bit colour-index
//            framebuffer. Takes one fill command per valid/ready handshake,
//            clips it to the visible screen, then issues one framebuffer
//            write per cycle in row-major order. Writes back off while the
//            memory stalls.
// Revision : 1.0 - initial release
// ============================================================================
module vga_rect_writer #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19,
    parameter int IDX_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x,
    input  logic [8:0]        cmd_y,
    input  logic [9:0]        cmd_w,
    input  logic [8:0]        cmd_h,
    input  logic [IDX_W-1:0]  cmd_index,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [IDX_W-1:0]  wr_data,
    input  logic              wr_stall,
    output logic              busy,
    output logic              done
);

    // Clip limits at one bit wider than the coordinates so x+w and y+h
    // can never wrap.
    localparam logic [10:0]       c_H_RES_X   = 11'(H_RES);
    localparam logic [9:0]        c_V_RES_Y   = 10'(V_RES);
    localparam logic [9:0]        c_H_RES_CMP = 10'(H_RES);
    localparam logic [8:0]        c_V_RES_CMP = 9'(V_RES);
    localparam logic [ADDR_W-1:0] c_STRIDE    = ADDR_W'(H_RES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_FILL  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;

    // Latched command
    logic [9:0]        r_x;
    logic [8:0]        r_y;
    logic [9:0]        r_w;
    logic [8:0]        r_h;
    logic [IDX_W-1:0]  r_index;

    // Walk state
    logic [10:0]       r_x_end;
    logic [9:0]        r_y_end;
    logic [ADDR_W-1:0] r_row_base;
    logic [9:0]        r_cx;
    logic [8:0]        r_cy;

    // Registered outputs
    logic              r_cmd_ready;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [IDX_W-1:0]  r_wr_data;
    logic              r_busy;
    logic              r_done;

    // Setup-time arithmetic on the latched command
    logic [10:0]       w_x_sum;
    logic [9:0]        w_y_sum;
    logic [10:0]       w_x_end;
    logic [9:0]        w_y_end;
    logic              w_empty;
    logic [ADDR_W-1:0] w_row_base0;

    // Fill-time position tests
    logic              w_last_col;
    logic              w_last_row;
    logic [ADDR_W-1:0] w_next_row_base;

    // Clip window, empty detection and first row base (y*640 as two shifts)
    always_comb begin
        w_x_sum     = {1'b0, r_x} + {1'b0, r_w};
        w_y_sum     = {1'b0, r_y} + {1'b0, r_h};
        w_x_end     = (w_x_sum > c_H_RES_X) ? c_H_RES_X : w_x_sum;
        w_y_end     = (w_y_sum > c_V_RES_Y) ? c_V_RES_Y : w_y_sum;
        w_empty     = (r_w == 10'd0) || (r_h == 9'd0) ||
                      (r_x >= c_H_RES_CMP) || (r_y >= c_V_RES_CMP);
        w_row_base0 = (ADDR_W'(r_y) << 9) + (ADDR_W'(r_y) << 7);
    end

    // Position of the beat currently on the write port
    always_comb begin
        w_last_col      = ({1'b0, r_cx} == (r_x_end - 11'd1));
        w_last_row      = ({1'b0, r_cy} == (r_y_end - 10'd1));
        w_next_row_base = r_row_base + c_STRIDE;
    end

    // Command sequencer and write-port driver
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_w         <= '0;
            r_h         <= '0;
            r_index     <= '0;
            r_x_end     <= '0;
            r_y_end     <= '0;
            r_row_base  <= '0;
            r_cx        <= '0;
            r_cy        <= '0;
            r_cmd_ready <= 1'b1;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                // DONE is also ready, so back-to-back commands lose no cycle
                S_IDLE, S_DONE: begin
                    if (cmd_valid) begin
                        r_x         <= cmd_x;
                        r_y         <= cmd_y;
                        r_w         <= cmd_w;
                        r_h         <= cmd_h;
                        r_index     <= cmd_index;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_SETUP;
                    end else begin
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                S_SETUP: begin
                    r_x_end <= w_x_end;
                    r_y_end <= w_y_end;
                    if (w_empty) begin
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_row_base <= w_row_base0;
                        r_cx       <= r_x;
                        r_cy       <= r_y;
                        r_wr_en    <= 1'b1;
                        r_wr_addr  <= w_row_base0 + ADDR_W'(r_x);
                        r_wr_data  <= r_index;
                        r_state    <= S_FILL;
                    end
                end

                // A stalled beat leaves every write output untouched
                S_FILL: begin
                    if (!wr_stall) begin
                        if (w_last_col && w_last_row) begin
                            r_wr_en     <= 1'b0;
                            r_done      <= 1'b1;
                            r_busy      <= 1'b0;
                            r_cmd_ready <= 1'b1;
                            r_state     <= S_DONE;
                        end else if (w_last_col) begin
                            r_cx       <= r_x;
                            r_cy       <= r_cy + 9'd1;
                            r_row_base <= w_next_row_base;
                            r_wr_addr  <= w_next_row_base + ADDR_W'(r_x);
                        end else begin
                            r_cx      <= r_cx + 10'd1;
                            r_wr_addr <= r_wr_addr + ADDR_W'(1);
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_vga_rect_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_rect_writer
// Brief    : Scoreboard bench for vga_rect_writer. Stimulus pushes the
//            expected write beats and done pulses (with their cycle) into a
//            queue; a negedge monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_rect_writer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_x = '0;
    logic [8:0]  cmd_y = '0;
    logic [9:0]  cmd_w = '0;
    logic [8:0]  cmd_h = '0;
    logic [7:0]  cmd_index = '0;
    logic        wr_en;
    logic [18:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_stall = 1'b0;
    logic        busy;
    logic        done;

    vga_rect_writer #(
        .H_RES (640),
        .V_RES (480),
        .ADDR_W(19),
        .IDX_W (8)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_x    (cmd_x),
        .cmd_y    (cmd_y),
        .cmd_w    (cmd_w),
        .cmd_h    (cmd_h),
        .cmd_index(cmd_index),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_stall (wr_stall),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit is_done;
        int addr;
        int data;
        int cyc;
    } ev_t;

    ev_t sb[$];
    int  n_pass   = 0;
    int  n_total  = 0;
    int  t_accept = 0;
    bit  mon_en   = 1'b0;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // rel is the cycle number counted from the accept edge
    task automatic push_w(input int addr, input int data, input int rel);
        ev_t e;
        e.is_done = 1'b0; e.addr = addr; e.data = data; e.cyc = t_accept + rel - 1;
        sb.push_back(e);
    endtask

    task automatic push_d(input int rel);
        ev_t e;
        e.is_done = 1'b1; e.addr = 0; e.data = 0; e.cyc = t_accept + rel - 1;
        sb.push_back(e);
    endtask

    // Present a command and return one #1 after the edge that accepts it
    task automatic issue(input int x, input int y, input int w, input int h, input int idx);
        int n;
        cmd_x = 10'(x); cmd_y = 9'(y); cmd_w = 10'(w); cmd_h = 9'(h);
        cmd_index = 8'(idx);
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) chk(1'b0, "accept_timeout", n, 0);
        @(posedge clock);
        #1;
        t_accept = cyc;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) chk(1'b0, "drain_timeout", sb.size(), 0);
        repeat (2) @(negedge clock);
    endtask

    // Monitor: ordered scoreboard of completed beats and done pulses
    initial begin
        ev_t e;
        bit  prev_stall;
        int  hold_addr;
        int  hold_data;
        prev_stall = 1'b0;
        hold_addr  = 0;
        hold_data  = 0;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                chk(cmd_ready == !busy, "ready_vs_busy", int'(cmd_ready), int'(!busy));
                if (prev_stall)
                    chk(wr_en && int'(wr_addr) == hold_addr && int'(wr_data) == hold_data,
                        "stall_hold", int'(wr_addr), hold_addr);
                if (wr_en && !wr_stall) begin
                    if (sb.size() == 0 || sb[0].is_done) begin
                        chk(1'b0, "unexpected_write", int'(wr_addr), -1);
                    end else begin
                        e = sb.pop_front();
                        chk(int'(wr_addr) == e.addr && int'(wr_data) == e.data && cyc == e.cyc,
                            $sformatf("write_beat(cyc %0d exp %0d data %0h exp %0h)",
                                      cyc, e.cyc, wr_data, e.data),
                            int'(wr_addr), e.addr);
                    end
                end
                if (done) begin
                    if (sb.size() == 0 || !sb[0].is_done) begin
                        chk(1'b0, "unexpected_done", cyc, -1);
                    end else begin
                        e = sb.pop_front();
                        chk(cyc == e.cyc, "done_cycle", cyc, e.cyc);
                    end
                end
                prev_stall = wr_en && wr_stall;
                hold_addr  = int'(wr_addr);
                hold_data  = int'(wr_data);
            end
        end
    end

    initial begin
        // Reset held two cycles
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk(wr_en == 1'b0,     "rst_wr_en",     int'(wr_en),     0);
        chk(busy == 1'b0,      "rst_busy",      int'(busy),      0);
        chk(done == 1'b0,      "rst_done",      int'(done),      0);
        chk(cmd_ready == 1'b1, "rst_cmd_ready", int'(cmd_ready), 1);
        chk(wr_addr == 19'd0,  "rst_wr_addr",   int'(wr_addr),   0);
        chk(wr_data == 8'd0,   "rst_wr_data",   int'(wr_data),   0);
        mon_en = 1'b1;

        // Basic 3x2 fill; fields change after accept and must be ignored
        issue(2, 1, 3, 2, 8'h2A);
        cmd_valid = 1'b0;
        cmd_x = 10'd5; cmd_w = 10'd100; cmd_index = 8'hFF;
        push_w(642, 8'h2A, 2); push_w(643, 8'h2A, 3); push_w(644, 8'h2A, 4);
        push_w(1282, 8'h2A, 5); push_w(1283, 8'h2A, 6); push_w(1284, 8'h2A, 7);
        push_d(8);
        drain();

        // Clipped at the bottom-right corner
        issue(638, 479, 5, 4, 8'h11);
        cmd_valid = 1'b0;
        push_w(307198, 8'h11, 2); push_w(307199, 8'h11, 3);
        push_d(4);
        drain();

        // Empty commands: zero width, off-screen x, off-screen y
        issue(10, 10, 0, 5, 8'h33);
        cmd_valid = 1'b0;
        push_d(2);
        drain();
        issue(700, 0, 4, 4, 8'h34);
        cmd_valid = 1'b0;
        push_d(2);
        drain();
        issue(0, 480, 4, 4, 8'h35);
        cmd_valid = 1'b0;
        push_d(2);
        drain();

        // Stall on cycles 3..5 with a second command held on the bus
        issue(2, 1, 3, 2, 8'h2A);
        cmd_x = 10'd0; cmd_y = 9'd0; cmd_w = 10'd1; cmd_h = 9'd1; cmd_index = 8'h55;
        push_w(642, 8'h2A, 2); push_w(643, 8'h2A, 6); push_w(644, 8'h2A, 7);
        push_w(1282, 8'h2A, 8); push_w(1283, 8'h2A, 9); push_w(1284, 8'h2A, 10);
        push_d(11);
        push_w(0, 8'h55, 13);
        push_d(14);
        repeat (2) @(posedge clock);
        #1 wr_stall = 1'b1;
        repeat (3) @(posedge clock);
        #1 wr_stall = 1'b0;
        repeat (6) @(posedge clock);
        #1 cmd_valid = 1'b0;
        drain();

        // Reset in the middle of a fill, then a fresh 1x1 command
        issue(2, 1, 3, 2, 8'h2A);
        cmd_valid = 1'b0;
        push_w(642, 8'h2A, 2); push_w(643, 8'h2A, 3); push_w(644, 8'h2A, 4);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        chk(wr_en == 1'b0,     "midrst_wr_en",     int'(wr_en),     0);
        chk(busy == 1'b0,      "midrst_busy",      int'(busy),      0);
        chk(cmd_ready == 1'b1, "midrst_cmd_ready", int'(cmd_ready), 1);
        reset = 1'b0;
        issue(0, 0, 1, 1, 8'h7E);
        cmd_valid = 1'b0;
        push_w(0, 8'h7E, 2);
        push_d(3);
        drain();

        chk(sb.size() == 0, "queue_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
